// File: rtl/sel_rs_pkg.sv
// Shared types and constants for the select-unit reservation station.
// rs_entry_t is the default-width view of one station slot.
package sel_rs_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_TAG_W  = 4;

  localparam int FLAG_WB_PC = 0;
  localparam int FLAG_IMM   = 1;

  typedef struct packed {
    logic                       valid;
    logic [DEF_DATA_W-1:0]      operand;
    logic [1:0][DEF_TAG_W-1:0]  dep_tag;
    logic [1:0]                 dep_rdy;
    logic [1:0][DEF_DATA_W-1:0] dep_val;
    logic [7:0]                 wbs;
    logic [7:0]                 flags;
    logic [DEF_TAG_W-1:0]       robid;
  } rs_entry_t;

endpackage

// File: rtl/sel_rs_wakeup.sv
// Combinational CDB snoop for one slot: a pending source whose tag matches the
// broadcast becomes ready and takes the broadcast value.
module rs_entry_wakeup #(
  parameter int DATA_W = 8,
  parameter int TAG_W  = 4
) (
  input  logic                   cdb_valid,
  input  logic [TAG_W-1:0]       cdb_id,
  input  logic [DATA_W-1:0]      cdb_val,
  input  logic                   valid,
  input  logic [1:0][TAG_W-1:0]  dep_tag,
  input  logic [1:0]             dep_rdy_in,
  input  logic [1:0][DATA_W-1:0] dep_val_in,
  output logic [1:0]             dep_rdy_out,
  output logic [1:0][DATA_W-1:0] dep_val_out
);

  always_comb begin
    dep_rdy_out = dep_rdy_in;
    dep_val_out = dep_val_in;
    for (int k = 0; k < 2; k++) begin
      if (valid && cdb_valid && !dep_rdy_in[k] && (dep_tag[k] == cdb_id)) begin
        dep_rdy_out[k] = 1'b1;
        dep_val_out[k] = cdb_val;
      end
    end
  end

endmodule

// File: rtl/sel_rs.sv
// Reservation station feeding the select FU: compacting age-ordered queue with
// CDB wakeup and oldest-ready issue through a registered FU interface.
module sel_rs
  import sel_rs_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAG_W  = DEF_TAG_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [DATA_W-1:0]          disp_operand,
  input  logic [1:0][TAG_W-1:0]      disp_dep_tag,
  input  logic [1:0]                 disp_dep_rdy,
  input  logic [1:0][DATA_W-1:0]     disp_dep_val,
  input  logic [7:0]                 disp_wbs,
  input  logic [7:0]                 disp_flags,
  input  logic [TAG_W-1:0]           disp_robid,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_id,
  input  logic [DATA_W-1:0]          cdb_val,
  input  logic                       fu_busy,
  output logic                       issue_transmit,
  output logic [DATA_W-1:0]          issue_operand,
  output logic [1:0][DATA_W-1:0]     issue_depvals,
  output logic [7:0]                 issue_wbs,
  output logic [7:0]                 issue_flags,
  output logic [TAG_W-1:0]           issue_robid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  // Local copy of the slot layout so widths follow this instance's parameters.
  typedef struct packed {
    logic                   valid;
    logic [DATA_W-1:0]      operand;
    logic [1:0][TAG_W-1:0]  dep_tag;
    logic [1:0]             dep_rdy;
    logic [1:0][DATA_W-1:0] dep_val;
    logic [7:0]             wbs;
    logic [7:0]             flags;
    logic [TAG_W-1:0]       robid;
  } entry_t;

  entry_t                 entries  [DEPTH];
  entry_t                 woke     [DEPTH];
  entry_t                 upper    [DEPTH];
  entry_t                 nxt      [DEPTH];
  logic [1:0]             woke_rdy [DEPTH];
  logic [1:0][DATA_W-1:0] woke_val [DEPTH];

  entry_t                 disp_entry;
  logic [1:0]             disp_rdy_eff;
  logic [1:0]             disp_rdy_snoop;
  logic [1:0][DATA_W-1:0] disp_val_snoop;

  logic                   sel_found;
  logic [IDX_W-1:0]       sel_idx;
  logic                   issue_fire;
  logic                   disp_fire;
  logic [CNT_W-1:0]       wr_idx;
  logic [CNT_W-1:0]       count_nxt;

  for (genvar g = 0; g < DEPTH; g++) begin : g_wake
    rs_entry_wakeup #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_wake (
      .cdb_valid   (cdb_valid),
      .cdb_id      (cdb_id),
      .cdb_val     (cdb_val),
      .valid       (entries[g].valid),
      .dep_tag     (entries[g].dep_tag),
      .dep_rdy_in  (entries[g].dep_rdy),
      .dep_val_in  (entries[g].dep_val),
      .dep_rdy_out (woke_rdy[g]),
      .dep_val_out (woke_val[g])
    );
  end

  // An immediate replaces source 1, so that source never waits.
  assign disp_rdy_eff = {disp_dep_rdy[1] | disp_flags[FLAG_IMM], disp_dep_rdy[0]};

  rs_entry_wakeup #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_wake_disp (
    .cdb_valid   (cdb_valid),
    .cdb_id      (cdb_id),
    .cdb_val     (cdb_val),
    .valid       (1'b1),
    .dep_tag     (disp_dep_tag),
    .dep_rdy_in  (disp_rdy_eff),
    .dep_val_in  (disp_dep_val),
    .dep_rdy_out (disp_rdy_snoop),
    .dep_val_out (disp_val_snoop)
  );

  always_comb begin
    disp_entry         = '0;
    disp_entry.valid   = 1'b1;
    disp_entry.operand = disp_operand;
    disp_entry.dep_tag = disp_dep_tag;
    disp_entry.dep_rdy = disp_rdy_snoop;
    disp_entry.dep_val = disp_val_snoop;
    disp_entry.wbs     = disp_wbs;
    disp_entry.flags   = disp_flags;
    disp_entry.robid   = disp_robid;
  end

  // Oldest-first select works on registered state, so a fresh wakeup or
  // dispatch waits one cycle before it can be chosen.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (entries[i].valid && (entries[i].dep_rdy == 2'b11)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign disp_ready = (count < CNT_W'(DEPTH));
  assign disp_fire  = disp_valid && disp_ready;
  assign issue_fire = sel_found && !fu_busy && !issue_transmit;
  assign wr_idx     = count - CNT_W'(issue_fire);
  assign count_nxt  = count + CNT_W'(disp_fire) - CNT_W'(issue_fire);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i]         = entries[i];
      woke[i].dep_rdy = woke_rdy[i];
      woke[i].dep_val = woke_val[i];
      upper[i]        = '0;
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      upper[i] = woke[i + 1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      nxt[i] = (issue_fire && (IDX_W'(i) >= sel_idx)) ? upper[i] : woke[i];
      if (disp_fire && (wr_idx == CNT_W'(i))) begin
        nxt[i] = disp_entry;
      end
    end
  end

  // Flush clears the queue and kills the pending pulse but keeps the last
  // issued payload on the FU bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      count          <= '0;
      issue_transmit <= 1'b0;
      issue_operand  <= '0;
      issue_depvals  <= '0;
      issue_wbs      <= '0;
      issue_flags    <= '0;
      issue_robid    <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      count          <= '0;
      issue_transmit <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= nxt[i];
      end
      count          <= count_nxt;
      issue_transmit <= issue_fire;
      if (issue_fire) begin
        issue_operand <= entries[sel_idx].operand;
        issue_depvals <= entries[sel_idx].dep_val;
        issue_wbs     <= entries[sel_idx].wbs;
        issue_flags   <= entries[sel_idx].flags;
        issue_robid   <= entries[sel_idx].robid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (count <= CNT_W'(DEPTH))
        else $error("sel_rs count overflow");
    end
  end

endmodule
